// File: rtl/cnn_sched_pkg.sv
// Shared types and defaults for the CNN tile scheduler.
// Optional watchdog is enabled by defining CNN_SCHED_WDOG_EN.
package cnn_sched_pkg;

    localparam int ADDR_W_DEF         = 12;
    localparam int CNT_W_DEF          = 12;
    localparam int MATRIX_STRIDE_DEF  = 1;
    localparam int WEIGHT_STRIDE_DEF  = 0;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    // Cycles per tile against an engine that holds busy for two cycles.
    localparam int TILE_CYCLES = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FINISH    = 3'd5
    } sched_state_e;

endpackage

// File: rtl/cnn_sched_if.sv
// Host-control and engine signals of the tile scheduler, bundled as one interface.
// master = scheduler side, slave = host/engine side.
interface cnn_sched_if #(
    parameter int ADDR_W = cnn_sched_pkg::ADDR_W_DEF,
    parameter int CNT_W  = cnn_sched_pkg::CNT_W_DEF
);
    import cnn_sched_pkg::*;

    // Handshake: start is a request sampled only in IDLE (ignored while abort is high);
    // engine_go is a one-cycle strobe issued only while engine_busy is low, and the engine
    // acknowledges by raising busy, then signals completion by dropping it again.
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  tile_count;
    logic [ADDR_W-1:0] matrix_base;
    logic [ADDR_W-1:0] weight_base;
    logic [ADDR_W-1:0] out_base;
    logic              engine_go;
    logic              engine_busy;
    logic [ADDR_W-1:0] tile_matrix_addr;
    logic [ADDR_W-1:0] tile_weight_addr;
    logic [ADDR_W-1:0] tile_write_addr;
    logic              active;
    logic              done;
    logic [CNT_W-1:0]  tiles_done;
    logic              aborted;
    logic              error;
    sched_state_e      dbg_state;

    modport master (
        input  start, abort, tile_count, matrix_base, weight_base, out_base, engine_busy,
        output engine_go, tile_matrix_addr, tile_weight_addr, tile_write_addr,
               active, done, tiles_done, aborted, error, dbg_state
    );

    modport slave (
        output start, abort, tile_count, matrix_base, weight_base, out_base, engine_busy,
        input  engine_go, tile_matrix_addr, tile_weight_addr, tile_write_addr,
               active, done, tiles_done, aborted, error, dbg_state
    );

endinterface

// File: rtl/cnn_sched_wdog.sv
// Watchdog counter for the tile scheduler's engine-wait states.
// Only instantiated when CNN_SCHED_WDOG_EN is defined.
module cnn_sched_wdog
    import cnn_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Fires during the TIMEOUT_CYCLES-th consecutive cycle spent waiting.
    assign expired = run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/cnn_tile_scheduler.sv
// Walks the XNOR convolution engine over a list of tiles, one go/busy exchange per tile.
// Define CNN_SCHED_WDOG_EN to add a watchdog on the engine-wait states.
module cnn_tile_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int MATRIX_STRIDE  = MATRIX_STRIDE_DEF,
    parameter int WEIGHT_STRIDE  = WEIGHT_STRIDE_DEF
`ifdef CNN_SCHED_WDOG_EN
   ,parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic         clk,
    input  logic         reset,
    cnn_sched_if.master  bus
);

    localparam logic [ADDR_W-1:0] M_STEP = ADDR_W'(MATRIX_STRIDE);
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(WEIGHT_STRIDE);
    localparam logic [ADDR_W-1:0] O_STEP = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);

    sched_state_e      state_q;
    logic              go_q;
    logic              active_q;
    logic              done_q;
    logic              aborted_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] oaddr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  tiles_done_q;
    logic [CNT_W-1:0]  tiles_done_d;
    logic              abort_hit;
    logic              start_ok;
    logic              timeout_hit;

    assign tiles_done_d = tiles_done_q + ONE;
    assign abort_hit    = bus.abort && (state_q != ST_IDLE);
    assign start_ok     = (state_q == ST_IDLE) && bus.start && !bus.abort;

`ifdef CNN_SCHED_WDOG_EN
    logic wdog_clear;
    logic wdog_run;
    logic error_q;

    // Clear one cycle ahead so the count starts at zero in the first wait cycle.
    assign wdog_clear = ((state_q == ST_ISSUE) && go_q) ||
                        ((state_q == ST_WAIT_ACK) && bus.engine_busy);
    assign wdog_run   = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);

    cnn_sched_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .run     (wdog_run),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (start_ok) begin
            error_q <= 1'b0;
        end else if (timeout_hit && !abort_hit) begin
            error_q <= 1'b1;
        end
    end

    assign bus.error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.error   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            go_q         <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            maddr_q      <= '0;
            waddr_q      <= '0;
            oaddr_q      <= '0;
            count_q      <= '0;
            tiles_done_q <= '0;
        end else begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
            if (abort_hit) begin
                state_q   <= ST_IDLE;
                active_q  <= 1'b0;
                aborted_q <= 1'b1;
            end else if (timeout_hit) begin
                state_q  <= ST_IDLE;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_ok) begin
                            maddr_q      <= bus.matrix_base;
                            waddr_q      <= bus.weight_base;
                            oaddr_q      <= bus.out_base;
                            count_q      <= bus.tile_count;
                            tiles_done_q <= '0;
                            aborted_q    <= 1'b0;
                            active_q     <= 1'b1;
                            if (bus.tile_count == '0) begin
                                state_q <= ST_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_ISSUE;
                                go_q    <= !bus.engine_busy;
                            end
                        end
                    end
                    // go is registered: it is raised the cycle after busy is seen low.
                    ST_ISSUE: begin
                        if (go_q) begin
                            state_q <= ST_WAIT_ACK;
                        end else begin
                            go_q <= !bus.engine_busy;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (bus.engine_busy) begin
                            state_q <= ST_WAIT_DONE;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (!bus.engine_busy) begin
                            state_q <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        tiles_done_q <= tiles_done_d;
                        maddr_q      <= maddr_q + M_STEP;
                        waddr_q      <= waddr_q + W_STEP;
                        oaddr_q      <= oaddr_q + O_STEP;
                        if (tiles_done_d == count_q) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            go_q    <= !bus.engine_busy;
                        end
                    end
                    ST_FINISH: begin
                        state_q  <= ST_IDLE;
                        active_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.engine_go        = go_q;
    assign bus.tile_matrix_addr = maddr_q;
    assign bus.tile_weight_addr = waddr_q;
    assign bus.tile_write_addr  = oaddr_q;
    assign bus.active           = active_q;
    assign bus.done             = done_q;
    assign bus.tiles_done       = tiles_done_q;
    assign bus.aborted          = aborted_q;
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_cnn_tile_scheduler.sv
// Randomized scoreboard bench for cnn_tile_scheduler with a behavioural engine model.
// The watchdog scenario only runs when CNN_SCHED_WDOG_EN is defined.
module tb_cnn_tile_scheduler;
    import cnn_sched_pkg::*;

    localparam int AW = 12;
    localparam int CW = 12;
    localparam int MS = 1;
    localparam int WS = 0;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;

    cnn_sched_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    cnn_tile_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    int s0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- engine model: busy for eng_len cycles after each go ----------------
    int eng_len  = 2;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.engine_go) busy_cnt <= eng_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.engine_busy = (busy_cnt != 0);

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [47:0] exp_go_q[$];   // {rel_cycle, matrix, weight, write}
    logic [23:0] exp_done_q[$]; // {rel_cycle, tiles_done}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] rel_now();
        return 12'(cyc - s0);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.engine_go) begin
                if (exp_go_q.size() == 0) begin
                    check("go_unexpected", 64'(bus.engine_go), 64'(0));
                end else begin
                    check("go_event",
                          64'({rel_now(), bus.tile_matrix_addr, bus.tile_weight_addr, bus.tile_write_addr}),
                          64'(exp_go_q.pop_front()));
                end
            end
            if (bus.done) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", 64'(bus.done), 64'(0));
                end else begin
                    check("done_event", 64'({rel_now(), bus.tiles_done}), 64'(exp_done_q.pop_front()));
                end
            end
        end
    end

    // ---------------- reference model (plain arithmetic over the tile list) ----------------
    task automatic push_go(input int rel, input logic [11:0] m, input logic [11:0] w, input logic [11:0] o);
        exp_go_q.push_back({12'(rel), m, w, o});
    endtask

    task automatic push_run(input int n, input logic [11:0] mb, input logic [11:0] wb,
                            input logic [11:0] ob, input int first_go);
        int tile_len;
        tile_len = eng_len + 3;
        for (int k = 0; k < n; k++) begin
            push_go(first_go + k * tile_len, mb + 12'(k * MS), wb + 12'(k * WS), ob + 12'(k));
        end
        if (n == 0) exp_done_q.push_back({12'(1), 12'(0)});
        else        exp_done_q.push_back({12'(first_go + n * tile_len), 12'(n)});
    endtask

    // ---------------- drivers (called at a negedge = cycle 0 of the run) ----------------
    task automatic issue_start(input int n, input logic [11:0] mb, input logic [11:0] wb, input logic [11:0] ob);
        bus.tile_count  = 12'(n);
        bus.matrix_base = mb;
        bus.weight_base = wb;
        bus.out_base    = ob;
        bus.start       = 1'b1;
        s0              = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.active) break;
        end
        if (bus.active) check("idle_timeout", 64'(bus.active), 64'(0));
    endtask

    task automatic post_checks(input int n, input logic [11:0] mb, input logic [11:0] wb, input logic [11:0] ob);
        check("tiles_done", 64'(bus.tiles_done), 64'(n));
        check("aborted_clear", 64'(bus.aborted), 64'(0));
        check("error_clear", 64'(bus.error), 64'(0));
        check("final_addrs", 64'({bus.tile_matrix_addr, bus.tile_weight_addr, bus.tile_write_addr}),
              64'({mb + 12'(n * MS), wb + 12'(n * WS), ob + 12'(n)}));
    endtask

    task automatic full_run(input int n, input logic [11:0] mb, input logic [11:0] wb, input logic [11:0] ob);
        push_run(n, mb, wb, ob, 1);
        issue_start(n, mb, wb, ob);
        wait_idle(n * (eng_len + 3) + 10);
        post_checks(n, mb, wb, ob);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({bus.engine_go, bus.tile_matrix_addr, bus.tile_weight_addr, bus.tile_write_addr,
                         bus.active, bus.done, bus.tiles_done, bus.aborted, bus.error}), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int g1, restart_go, n;
        logic [11:0] mb, wb, ob;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.tile_count  = '0;
        bus.matrix_base = '0;
        bus.weight_base = '0;
        bus.out_base    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Basic run
        eng_len = 2;
        full_run(3, 12'h010, 12'h020, 12'h100);

        // Zero count
        full_run(0, 12'h0AA, 12'h0BB, 12'h0CC);

        // Matrix address wrap
        full_run(2, 12'hFFF, 12'h007, 12'hFFF);

        // Abort in WAIT_DONE of tile 1, with a slow engine, then immediate restart
        eng_len = 6;
        g1 = 1 + (eng_len + 3);
        push_go(1, 12'h040, 12'h050, 12'h060);
        push_go(g1, 12'h041, 12'h050, 12'h061);
        issue_start(3, 12'h040, 12'h050, 12'h060);
        repeat (11) @(negedge clk);
        check("in_wait_done_before_abort", 64'(bus.active), 64'(1));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_idle", 64'(bus.active), 64'(0));
        check("abort_flag", 64'(bus.aborted), 64'(1));
        check("abort_tiles", 64'(bus.tiles_done), 64'(1));
        // engine stays busy through cycle g1+eng_len; go may only follow a busy-low cycle
        restart_go = (g1 + eng_len + 1) - (cyc - s0) + 1;
        push_go(restart_go, 12'h200, 12'h300, 12'h400);
        exp_done_q.push_back({12'(restart_go + eng_len + 3), 12'(1)});
        issue_start(1, 12'h200, 12'h300, 12'h400);
        wait_idle(40);
        post_checks(1, 12'h200, 12'h300, 12'h400);

        // start and abort together in IDLE
        eng_len = 2;
        bus.tile_count = 12'd3;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("collision_inactive", 64'(bus.active), 64'(0));
        @(negedge clk);
        check("collision_still_idle", 64'({bus.active, bus.tiles_done}), 64'({1'b0, 12'(1)}));

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            n       = $urandom_range(0, 5);
            eng_len = $urandom_range(1, 4);
            mb      = 12'($urandom_range(0, 4095));
            wb      = 12'($urandom_range(0, 4095));
            ob      = 12'($urandom_range(0, 4095));
            full_run(n, mb, wb, ob);
        end

        // Reset during WAIT_ACK
        eng_len = 2;
        push_go(1, 12'h123, 12'h456, 12'h789);
        issue_start(2, 12'h123, 12'h456, 12'h789);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero("reset_midrun");
        exp_go_q.delete();
        exp_done_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        full_run(2, 12'h123, 12'h456, 12'h789);

`ifdef CNN_SCHED_WDOG_EN
        // Engine never acknowledges: watchdog ends the run
        eng_len = 0;
        push_go(1, 12'h010, 12'h020, 12'h030);
        issue_start(1, 12'h010, 12'h020, 12'h030);
        repeat (TO) @(negedge clk);
        check("wdog_still_active", 64'(bus.active), 64'(1));
        @(negedge clk);
        check("wdog_active_fall", 64'(bus.active), 64'(0));
        check("wdog_error", 64'(bus.error), 64'(1));
        eng_len = 2;
        repeat (3) @(negedge clk);
        full_run(1, 12'h011, 12'h022, 12'h033);
`endif

        repeat (3) @(negedge clk);
        check("go_queue_drained", 64'(exp_go_q.size()), 64'(0));
        check("done_queue_drained", 64'(exp_done_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_tile_scheduler.md
# cnn_tile_scheduler

Sequences the binary XNOR convolution engine over a list of tiles. For each tile it places the matrix, weight and output addresses, pulses the engine's `go`, and tracks the engine's `busy` through one complete convolution. It then advances to the next tile. The block sits between the host control register interface and the convolution engine, and it is the only block that drives the engine's `go`.

## Interface
- `ADDR_W`, 12: width of all SRAM addresses.
- `CNT_W`, 12: width of the tile count and progress counter.
- `MATRIX_STRIDE`, 1: matrix address increment per tile.
- `WEIGHT_STRIDE`, 0: weight address increment per tile. A value of 0 means all tiles share one weight word.
- `TIMEOUT_CYCLES`, 64: watchdog limit. Used only when the watchdog is compiled in.

- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begins a run. Sampled only in IDLE.
- `abort`, in, 1: ends a run early. Effective in any state other than IDLE.
- `tile_count`, in, CNT_W: number of tiles. Sampled together with `start`.
- `matrix_base`, `weight_base`, `out_base`, in, ADDR_W: address of the first tile. Sampled together with `start`.
- `engine_go`, out, 1: go strobe to the engine.
- `engine_busy`, in, 1: busy signal from the engine.
- `tile_matrix_addr`, `tile_weight_addr`, `tile_write_addr`, out, ADDR_W: addresses for the current tile.
- `active`, out, 1: high in every state other than IDLE.
- `done`, out, 1: one-cycle pulse when a run completes normally.
- `tiles_done`, out, CNT_W: number of tiles completed in the current or most recent run.
- `aborted`, out, 1: sticky flag. Cleared by the next accepted `start`.
- `error`, out, 1: sticky watchdog flag. Cleared by the next accepted `start`.

## Operation
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- **IDLE:** `start`=1 and `abort`=0 in the same cycle does all of the following:
  - latches the base addresses into the three address outputs;
  - latches `tile_count` and clears `tiles_done`, `aborted` and `error`;
  - moves to ISSUE, or to FINISH when `tile_count`=0.
- **ISSUE:** `engine_go`=1 only while `engine_busy`=0.
  - Moves to WAIT_ACK on the first cycle in which `go` is driven.
  - While `engine_busy`=1, the block stays in ISSUE with `go`=0. This waits out an engine still finishing after an abort.
- **WAIT_ACK:** `engine_go`=0. Moves to WAIT_DONE when `engine_busy`=1.
- **WAIT_DONE:** moves to NEXT when `engine_busy`=0.
- **NEXT:**
  - `tiles_done`+=1, `tile_matrix_addr`+=MATRIX_STRIDE, `tile_weight_addr`+=WEIGHT_STRIDE, `tile_write_addr`+=1.
  - Moves to FINISH when the new `tiles_done` equals the latched count; otherwise moves to ISSUE.
- **FINISH:** `done`=1 for exactly one cycle, then IDLE.
- **Address stability:** the three address outputs are constant from ISSUE through WAIT_DONE.
- **Arithmetic:** all increments are unsigned and wrap modulo 2^width. There is no saturation and no overflow flag.
- **`abort`** in ISSUE, WAIT_ACK, WAIT_DONE, NEXT or FINISH:
  - the next state is IDLE and `engine_go` is 0 from the next cycle;
  - `aborted` is set and `done` does not pulse;
  - `tiles_done` keeps its value; an increment in the same NEXT cycle is discarded.
- **Same-cycle priority:** `abort` beats `start` and beats every state transition.
- **`start` while not in IDLE:** ignored.

## Timing
- Against the engine (`busy` high for 2 cycles, starting the cycle after `go`):
  - With `start` high in cycle 0, ISSUE is in cycle 1 and each tile takes exactly 5 cycles.
  - `done` is high in cycle 5N+1.
  - `engine_go` for tile k is high in cycle 5k+1, where k is 0-based.
- The `tile_count`=0 run has `done` high in cycle 1.
- Reset asserted mid-run returns the block to IDLE immediately with all outputs 0. No `done` pulse follows.

## Configuration
- `CNN_SCHED_WDOG_EN` defined:
  - A counter clears on entry to WAIT_ACK or WAIT_DONE and increments each cycle spent in those states.
  - Reaching TIMEOUT_CYCLES sets `error`, moves to IDLE, and suppresses `done`.
- Undefined: the block waits indefinitely, `error` is tied to 0, and no counter logic exists.

## Structure
- `cnn_sched_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH);
  - default widths and strides;
  - per-tile latency constant TILE_CYCLES=5.
- One sub-module, `cnn_sched_wdog`: the watchdog counter. It has `clear`, `run` and `expired` ports and is instantiated only under `CNN_SCHED_WDOG_EN`.

## Test plan
- **Basic run:** reset, then `start` with count=3, matrix_base=0x010, weight_base=0x020, out_base=0x100, with the engine model attached.
  - Three `go` pulses in cycles 1, 6 and 11.
  - Write addresses 0x100, 0x101, 0x102; matrix addresses 0x010, 0x011, 0x012; weight address stays 0x020.
  - `done` in cycle 16; `tiles_done`=3.
- **Zero count:** `start` with count=0 gives no `go`, `done` in cycle 1 and `tiles_done`=0.
- **Abort mid-tile:** assert `abort` during the second tile's WAIT_DONE.
  - Result: IDLE next cycle, `aborted`=1, `tiles_done`=1, no `done`.
  - An immediate restart holds `go` low until `engine_busy`=0.
- **Collisions and wrap-around:**
  - `start` and `abort` in the same IDLE cycle: no run, `active` stays 0.
  - matrix_base=0xFFF with count=2: the second tile uses matrix address 0x000.
- **Watchdog (`CNN_SCHED_WDOG_EN`):** an engine model that never raises `busy` gives `error`=1 with `active` falling in cycle 2+TIMEOUT_CYCLES and no `done`.
- **Reset mid-run:** assert `reset` during WAIT_ACK. All outputs are 0 immediately; the next `start` runs normally.
